// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// With HAZ_PERF_CNT_EN defined the bundle also carries the stall/flush performance counters.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_uses_rs1_i;
    logic        id_uses_rs2_i;
    logic [4:0]  ex_rs1_i;
    logic [4:0]  ex_rs2_i;
    logic [4:0]  ex_rd_i;
    logic        ex_mem_read_i;
    logic [4:0]  mem_rd_i;
    logic        mem_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic        wb_reg_write_i;
    logic        branch_taken_i;
    logic        dmem_busy_i;
    logic        pc_en_o;
    logic        if_id_en_o;
    logic        id_ex_en_o;
    logic        ex_mem_en_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        ex_mem_flush_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [1:0]  state_o;
    logic        mem_err_o;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output ex_rs1_i, ex_rs2_i, ex_rd_i, ex_mem_read_i,
        output mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i,
        output branch_taken_i, dmem_busy_i,
        input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
        input  if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
        input  fwd_a_o, fwd_b_o, state_o, mem_err_o
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  ex_rs1_i, ex_rs2_i, ex_rd_i, ex_mem_read_i,
        input  mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i,
        input  branch_taken_i, dmem_busy_i,
        output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
        output if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
        output fwd_a_o, fwd_b_o, state_o, mem_err_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squashes, dmem wait freeze with watchdog.
// Optional HAZ_PERF_CNT_EN adds free-running stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_EXTRA = 1,
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int unsigned CNT_W       = 9
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FLUSH_INIT   = CNT_W'(FLUSH_EXTRA);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s;
    logic             if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;
    logic             run_eval_s, br_accept_s, load_use_s;
    logic [1:0]       fwd_a_s, fwd_b_s;

    // EX/MEM result takes precedence over the older WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] m_rd,
                                           input logic m_wr, input logic [4:0] w_rd,
                                           input logic w_wr);
        logic [1:0] sel;
        if (m_wr && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and load-use detection.
    always_comb begin
        fwd_a_s    = fwd_sel(hz.ex_rs1_i, hz.mem_rd_i, hz.mem_reg_write_i,
                             hz.wb_rd_i, hz.wb_reg_write_i);
        fwd_b_s    = fwd_sel(hz.ex_rs2_i, hz.mem_rd_i, hz.mem_reg_write_i,
                             hz.wb_rd_i, hz.wb_reg_write_i);
        load_use_s = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
                     ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                      (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));
    end

    // Next-state, counter, watchdog and pipeline control decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        id_ex_en_s     = 1'b1;
        ex_mem_en_s    = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        run_eval_s     = 1'b0;
        br_accept_s    = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                if (hz.dmem_busy_i) begin
                    {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
                end else begin
                    if_id_flush_s = 1'b1;
                    cnt_d         = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_busy_i) begin
                    {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (cnt_q == TIMEOUT_LAST) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    run_eval_s = 1'b1;
                end
            end
            ST_RUN: begin
                run_eval_s = 1'b1;
            end
            default: begin
                run_eval_s = 1'b1;
            end
        endcase

        // A released MEM_WAIT behaves exactly like RUN for this cycle.
        if (run_eval_s) begin
            if (hz.dmem_busy_i) begin
                {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
                cnt_d   = CNT_ONE;
                state_d = ST_MEM_WAIT;
                if (MEM_TIMEOUT <= 1) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end else if (hz.branch_taken_i) begin
                {if_id_flush_s, id_ex_flush_s, ex_mem_flush_s} = 3'b111;
                br_accept_s = 1'b1;
                if (FLUSH_EXTRA > 0) begin
                    cnt_d   = FLUSH_INIT;
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (load_use_s) begin
                pc_en_s       = 1'b0;
                if_id_en_s    = 1'b0;
                id_ex_flush_s = 1'b1;
                state_d       = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            br_accept_s = 1'b0;
        end
    end

    // State, counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign hz.pc_en_o        = rstn_i & pc_en_s;
    assign hz.if_id_en_o     = rstn_i & if_id_en_s;
    assign hz.id_ex_en_o     = rstn_i & id_ex_en_s;
    assign hz.ex_mem_en_o    = rstn_i & ex_mem_en_s;
    assign hz.if_id_flush_o  = rstn_i & if_id_flush_s;
    assign hz.id_ex_flush_o  = rstn_i & id_ex_flush_s;
    assign hz.ex_mem_flush_o = rstn_i & ex_mem_flush_s;
    assign hz.fwd_a_o        = rstn_i ? fwd_a_s : 2'b00;
    assign hz.fwd_b_o        = rstn_i ? fwd_b_s : 2'b00;
    assign hz.state_o        = state_q;
    assign hz.mem_err_o      = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        if (!pc_en_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (br_accept_s) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`endif
endmodule
